// File: rtl/div_if.sv
// Operand/result bundle for the sequential divider: the requester drives
// operands and the start pulse, the divider returns quotient, remainder and status.
interface div_if;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        div_by_zero;

  modport master (
    output dividend,
    output divisor,
    output start,
    input  quotient,
    input  remainder,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  dividend,
    input  divisor,
    input  start,
    output quotient,
    output remainder,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/div.sv
// 32-bit unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes on the load edge and flags div_by_zero.
module div (
  input  logic  clk,
  input  logic  reset_n,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [32:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dsr_reg;
  logic [5:0]  bit_cnt;

  logic        load_en;
  logic        iter_en;
  logic        zero_fast;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        unused_rem_sign;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  assign shifted = {rem_reg[31:0], quo_reg[31]};
  assign trial   = shifted - {1'b0, dsr_reg};

  // Restored remainders never go negative, so the top bit is only a borrow witness.
  assign unused_rem_sign = rem_reg[32];

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (bus.divisor == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    iter_en    = 1'b0;
    if (bus.start) begin
      // A start in any state reloads, which also aborts a division in flight.
      load_en    = 1'b1;
      state_next = zero_fast ? DONE : BUSY;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        BUSY: begin
          iter_en = 1'b1;
          if (bit_cnt == 6'd31) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_reg <= 33'd0;
      quo_reg <= 32'd0;
      dsr_reg <= 32'd0;
      bit_cnt <= 6'd0;
    end else if (load_en) begin
      dsr_reg <= bus.divisor;
      bit_cnt <= 6'd0;
      if (zero_fast) begin
        rem_reg <= {1'b0, bus.dividend};
        quo_reg <= 32'hFFFF_FFFF;
      end else begin
        rem_reg <= 33'd0;
        quo_reg <= bus.dividend;
      end
    end else if (iter_en) begin
      if (!trial[32]) begin
        rem_reg <= trial;
        quo_reg <= {quo_reg[30:0], 1'b1};
      end else begin
        rem_reg <= shifted;
        quo_reg <= {quo_reg[30:0], 1'b0};
      end
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  logic dz_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dz_reg <= 1'b0;
    end else if (load_en) begin
      dz_reg <= zero_fast;
    end
  end

  assign bus.div_by_zero = dz_reg;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.quotient  = quo_reg;
  assign bus.remainder = rem_reg[31:0];
  assign bus.done      = (state_reg == DONE);

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operands
// compared against plain '/' and '%' arithmetic.
module tb_div;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  div_if bus ();

  div dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results from the arithmetic definition of unsigned division.
  function automatic logic [31:0] ref_quo(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] ref_rem(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 0 : 32;
`else
    return 32;
`endif
  endfunction

  function automatic logic ref_dz(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Called just after a falling edge. Pulses start for one cycle and returns the
  // index of the clock edge after which done is first seen (edge 0 = load edge),
  // or -1 if it never rises within the budget. Returns at that falling edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.quotient, bus.remainder, bus.done, bus.div_by_zero} !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got q=%h r=%h done=%b dz=%b, want all 0",
               bus.quotient, bus.remainder, bus.done, bus.div_by_zero);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_div(32'd100, 32'd7, lat);
    tests_run++;
    if (lat !== 32 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_100_7: got lat=%0d q=%0d r=%0d dz=%b, want lat=32 q=14 r=2 dz=0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end else begin
      $display("[TB] basic 100/7 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
        tests_failed++;
        $display("[TB] FAIL hold_%0d: got done=%b q=%0d r=%0d, want done=1 q=14 r=2",
                 i, bus.done, bus.quotient, bus.remainder);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] a_tab [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd1234};
    logic [31:0] b_tab [5] = '{32'd1, 32'h8000_0000, 32'd10, 32'd3, 32'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run_div(a_tab[i], b_tab[i], lat);
      tests_run++;
      if (lat !== ref_lat(b_tab[i]) || bus.quotient !== ref_quo(a_tab[i], b_tab[i]) ||
          bus.remainder !== ref_rem(a_tab[i], b_tab[i]) || bus.div_by_zero !== ref_dz(b_tab[i])) begin
        tests_failed++;
        $display("[TB] FAIL boundary_%0d %h/%h: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                 i, a_tab[i], b_tab[i], lat, bus.quotient, bus.remainder, bus.div_by_zero,
                 ref_lat(b_tab[i]), ref_quo(a_tab[i], b_tab[i]), ref_rem(a_tab[i], b_tab[i]),
                 ref_dz(b_tab[i]));
      end else begin
        $display("[TB] boundary %h/%h -> q=%h r=%h lat=%0d dz=%b",
                 a_tab[i], b_tab[i], bus.quotient, bus.remainder, lat, bus.div_by_zero);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    int early_done;
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    early_done   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done !== 1'b0) early_done++;
    end
    run_div(32'd81, 32'd9, lat);
    tests_run++;
    if (early_done != 0 || lat !== 32 || bus.quotient !== 32'd9 || bus.remainder !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_restart: got early_done=%0d lat=%0d q=%0d r=%0d, want 0 32 9 0",
               early_done, lat, bus.quotient, bus.remainder);
    end else begin
      $display("[TB] abort 100/7 -> restart 81/9 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
    end
  endtask

  task automatic test_reset_mid();
    int late_done;
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.quotient, bus.remainder, bus.done, bus.div_by_zero} !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got q=%h r=%h done=%b dz=%b, want all 0",
               bus.quotient, bus.remainder, bus.done, bus.div_by_zero);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) late_done++;
    end
    tests_run++;
    if (late_done != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_done: got done high on %0d cycles, want 0", late_done);
    end else begin
      $display("[TB] reset mid-operation -> outputs cleared, no done");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(255, 1);
        2:       b = $urandom >> $urandom_range(31, 0);
        default: b = (i % 8 == 3) ? 32'd0 : a + 32'd1;
      endcase
      @(negedge clk);
      run_div(a, b, lat);
      tests_run++;
      if (lat !== ref_lat(b) || bus.quotient !== ref_quo(a, b) || bus.remainder !== ref_rem(a, b) ||
          bus.div_by_zero !== ref_dz(b)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d %h/%h: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                 i, a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero,
                 ref_lat(b), ref_quo(a, b), ref_rem(a, b), ref_dz(b));
      end else begin
        $display("[TB] random %h/%h -> q=%h r=%h", a, b, bus.quotient, bus.remainder);
      end
    end
  endtask

  // Each new start is raised in the very cycle done first rises.
  task automatic test_back_to_back();
    logic [31:0] a_tab [4] = '{32'd1000, 32'd77, 32'hDEAD_BEEF, 32'd50};
    logic [31:0] b_tab [4] = '{32'd0, 32'd11, 32'd3, 32'd50};
    int lat;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_div(a_tab[i], b_tab[i], lat);
      tests_run++;
      if (lat !== ref_lat(b_tab[i]) || bus.quotient !== ref_quo(a_tab[i], b_tab[i]) ||
          bus.remainder !== ref_rem(a_tab[i], b_tab[i]) || bus.div_by_zero !== ref_dz(b_tab[i])) begin
        tests_failed++;
        $display("[TB] FAIL b2b_%0d %h/%h: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                 i, a_tab[i], b_tab[i], lat, bus.quotient, bus.remainder, bus.div_by_zero,
                 ref_lat(b_tab[i]), ref_quo(a_tab[i], b_tab[i]), ref_rem(a_tab[i], b_tab[i]),
                 ref_dz(b_tab[i]));
      end else begin
        $display("[TB] back-to-back %h/%h -> q=%h r=%h lat=%0d",
                 a_tab[i], b_tab[i], bus.quotient, bus.remainder, lat);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Sequential 32-bit unsigned restoring divider: the inverse of the shift-add multiplier, in the same datapath family. It produces quotient and remainder one bit per clock, using a combined shift-left remainder/quotient register and a subtract-and-compare step. It includes its own control FSM and sits beside the multiplier in the arithmetic unit, using the same start/done handshake.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- dividend  in  32  unsigned dividend; sampled on the cycle `start` is high.
- divisor  in  32  unsigned divisor; sampled on the cycle `start` is high.
- start  in  1  single-cycle pulse; loads operands and begins division.
- quotient  out  32  quotient; valid while `done`=1.
- remainder  out  32  remainder; valid while `done`=1.
- done  out  1  result valid; held until the next `start` or reset.
- div_by_zero  out  1  divisor was zero; valid while `done`=1.

## Operation
- Registers:
  - `rem_reg` [32:0] (33 bits, holds the sign of the trial subtraction).
  - `quo_reg` [31:0].
  - `dsr_reg` [31:0].
  - `bit_cnt` [5:0].
- Outputs: `quotient`=`quo_reg`, `remainder`=`rem_reg[31:0]`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `start` -> BUSY.
  - BUSY: `bit_cnt`==31 on an iteration edge -> DONE.
  - DONE: `start` -> BUSY.
- Load (any state, `start`=1):
  - `rem_reg`<=0, `quo_reg`<=`dividend`, `dsr_reg`<=`divisor`, `bit_cnt`<=0, `done`<=0.
- Iteration (BUSY, `start`=0):
  - Form shifted value s = {`rem_reg`[31:0], `quo_reg`[31]}.
  - Compute d = s - {1'b0, `dsr_reg`}, 33 bits.
  - If d[32]==0: `rem_reg`<=d, `quo_reg`<={`quo_reg`[30:0],1}.
  - Else: `rem_reg`<=s, `quo_reg`<={`quo_reg`[30:0],0}.
  - Then `bit_cnt`++.
- Boundary conditions:
  - `start` in BUSY aborts the current division and reloads; no `done` pulse is issued for the aborted operation.
  - `start` in DONE drops `done` on the next edge and begins a new division.
  - Divisor 0 through the normal iteration path naturally yields `quotient`=0xFFFFFFFF and `remainder`=`dividend`.
  - `dividend` < `divisor` gives `quotient`=0 and `remainder`=`dividend`.
- During BUSY, `quotient` and `remainder` show partial values and are not valid.

## Timing
- Reset (`reset_n`=0, async): state=IDLE, all registers 0; `quotient`=0, `remainder`=0, `done`=0, `div_by_zero`=0.
- Reset deasserted mid-operation: the block returns to IDLE with outputs 0; any in-flight division is lost.
- Latency:
  - Edge 0 samples `start` and loads operands.
  - Edges 1..32 perform the 32 iterations.
  - `done`=1 after edge 32, i.e. 32 cycles after the `start` edge.
- Throughput: a new `start` may be issued the cycle `done` first rises.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `DIV_ZERO_FAST_EN`.
- Defined:
  - On the load edge, if `divisor`==0, the FSM goes directly to DONE.
  - `done`=1 one cycle after `start`.
  - `quotient`=0xFFFFFFFF, `remainder`=`dividend`, `div_by_zero`=1.
  - `div_by_zero` clears on the next `start`.
- Undefined:
  - Divisor 0 runs the full 32 iterations and gives the same quotient/remainder values.
  - `div_by_zero` is tied to 0.

## Test plan
- Basic division: `dividend`=100, `divisor`=7, `start` pulse.
  - `done` rises exactly 32 cycles later with `quotient`=14, `remainder`=2, held stable for 5 idle cycles.
- Maximum dividend: 0xFFFFFFFF / 1 -> `quotient`=0xFFFFFFFF, `remainder`=0.
- Large divisor: 0xFFFFFFFF / 0x80000000 -> `quotient`=1, `remainder`=0x7FFFFFFF.
- Dividend smaller than divisor: 5 / 10 -> `quotient`=0, `remainder`=5.
- Divide by zero: 1234 / 0.
  - With `DIV_ZERO_FAST_EN`: `done` after 1 cycle, `div_by_zero`=1, `quotient`=0xFFFFFFFF, `remainder`=1234.
  - Without it: `done` after 32 cycles, same `quotient`/`remainder`, `div_by_zero`=0.
- Abort and reset mid-operation:
  - Start 100/7, re-`start` with 81/9 at cycle 10 -> a single `done` 32 cycles after the second `start`, `quotient`=9, `remainder`=0.
  - Separately, pulse `reset_n` low at cycle 15 -> all outputs 0 immediately and `done` never rises.
